pipe_stage_skid: RTL and testbench
==================================

Name: pipe_stage_skid

Overview:
- Generic, parametrised pipeline stage register with a valid/ready handshake, a 2-entry skid buffer and synchronous flush.
- Successor to the fixed-payload, load-enabled stage registers. Any pipeline boundary (IF/ID, ID/EX, EX/MEM, MEM/WB) packs its payload (pc, instruction, decoded fields, control word, operands) into one WIDTH-bit vector and instantiates this block.
- Gives full throughput with registered upstream ready, so stall back-pressure never forms a combinational path across stages.

Parameters:
- WIDTH, 32, payload width in bits (>=1).
- CNT_WIDTH, 32, stall-counter width; used only when the optional feature is compiled in.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  kill all held entries (branch mispredict / exception).
- valid_i  input  1  upstream payload valid.
- data_i  input  WIDTH  upstream payload.
- ready_o  output  1  stage can accept; registered.
- valid_o  output  1  downstream payload valid.
- data_o  output  WIDTH  downstream payload.
- ready_i  input  1  downstream accepts.
- stall_cnt_o  output  CNT_WIDTH  back-pressure cycle count; present only with PIPE_STAGE_PERF_EN.

Behaviour:
- Storage: main entry (main_v, main_d) drives valid_o/data_o directly; skid entry (skid_v, skid_d). ready_o = !skid_v, taken from a flop with no combinational input.
- in_fire = valid_i & ready_o; out_fire = valid_o & ready_i.
- States (pipe_state_t): EMPTY (!main_v), ONE (main_v & !skid_v), TWO (main_v & skid_v). skid_v never 1 while main_v is 0.
- EMPTY: in_fire -> main<=data_i, ONE.
- ONE:
  - in_fire & out_fire -> main<=data_i, stay ONE.
  - in_fire & !out_fire -> skid<=data_i, TWO.
  - !in_fire & out_fire -> EMPTY.
  - neither -> hold.
- TWO: ready_o=0, so no input. out_fire -> main<=skid_d, skid_v<=0, ONE. Otherwise hold.
- Latency: data_i accepted in cycle N appears on data_o in cycle N+1 when the stage was EMPTY, or when it was ONE and main drained that cycle. Sustained throughput is 1 item/cycle.
- Ordering: strict FIFO. Nothing is duplicated or dropped except on flush.
- Stability: while valid_o & !ready_i, data_o and valid_o hold unchanged.
- Flush:
  - Next cycle main_v=0, skid_v=0, ready_o=1.
  - Flush overrides a same-cycle in_fire; that input is dropped.
  - An out_fire in the flush cycle still counts as consumed downstream.
  - Data flops hold their value; they are don't-care when invalid.
- Reset (rst high at the clock edge, including mid-transfer): valid_o=0, data_o='0, ready_o=1, skid cleared to 0, stall_cnt_o=0. Reset has priority over flush and all handshakes.
- Inputs are sampled only at the clk edge; no asynchronous paths.

Optional Feature:
- Macro: PIPE_STAGE_PERF_EN.
- Defined:
  - stall_cnt_o exists.
  - It increments by 1 each cycle valid_o & !ready_i, and saturates at all-ones.
  - It is cleared only by rst; flush does not clear it.
- Undefined: stall_cnt_o port and its counter logic are absent. All other behaviour is identical.

Decomposition:
- Package pipe_pkg holds:
  - pipe_state_t enum {EMPTY, ONE, TWO}.
  - localparam PIPE_DEFAULT_WIDTH = 32.
- Per-stage payload structs (e.g. id_ex_payload_t bundling pc, instruction, instruction_decoded_t, rv32i_control_word, rs1/rs2 values) go in rv32i_types.
- No sub-module. Each stage boundary instantiates pipe_stage_skid directly, with $bits(payload struct) as WIDTH.

Test Plan:
- Reset: hold rst 2 cycles with valid_i=1, data_i=32'hDEAD_BEEF -> valid_o=0, data_o=0, ready_o=1; first item appears one cycle after rst drops.
- Streaming: ready_i=1, send 0x1,0x2,0x3 on consecutive cycles -> data_o shows 0x1,0x2,0x3 on cycles N+1..N+3 with valid_o continuously 1.
- Back-pressure: send 0xA then 0xB, ready_i=0 from cycle N+1 for 3 cycles -> ready_o=0 after 0xB is captured; data_o holds 0xA; on release, 0xA then 0xB emerge in order, nothing lost.
- Flush in TWO: entries 0x10/0x11 held, assert flush with valid_i=1, data_i=0x12 -> next cycle valid_o=0, ready_o=1; 0x12 never emerges.
- Simultaneous in/out in ONE: main=0x20, valid_i=1 data_i=0x21, ready_i=1 -> next cycle data_o=0x21, state stays ONE, ready_o stays 1.
- PIPE_STAGE_PERF_EN with CNT_WIDTH=4: hold valid_o=1, ready_i=0 for 20 cycles -> stall_cnt_o saturates at 15; flush leaves it at 15; rst returns it to 0.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the generic pipeline stage register.
// State encoding of the main/skid occupancy and the default payload width.
package pipe_pkg;

   // Occupancy of a stage: nothing held, main only, main plus skid.
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } pipe_state_t;

   localparam int PIPE_DEFAULT_WIDTH = 32;

endpackage : pipe_pkg

// File: rtl/pipe_stage_skid.sv
// Generic pipeline stage register with valid/ready handshake, a 2-entry skid
// buffer and synchronous flush. The upstream ready comes straight from a flop,
// so back-pressure never forms a combinational path between stages.
// Optional stall counter (stall_cnt_o) is compiled in with PIPE_STAGE_PERF_EN.
module pipe_stage_skid
   import pipe_pkg::*;
#(
   parameter int WIDTH     = PIPE_DEFAULT_WIDTH,
   parameter int CNT_WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 flush,
   input  logic                 valid_i,
   input  logic [WIDTH-1:0]     data_i,
   output logic                 ready_o,
   output logic                 valid_o,
   output logic [WIDTH-1:0]     data_o,
   input  logic                 ready_i
`ifdef PIPE_STAGE_PERF_EN
   ,
   output logic [CNT_WIDTH-1:0] stall_cnt_o
`endif
);

   // Parameter sanity: empty marker block when a width is out of range.
   if (WIDTH < 1 || CNT_WIDTH < 1) begin : g_bad_width
   end

   pipe_state_t      state_reg, state_next;
   logic [WIDTH-1:0] main_d_reg, main_d_next;
   logic [WIDTH-1:0] skid_d_reg, skid_d_next;
   logic             ready_reg, ready_next;
   logic             in_fire, out_fire;

   assign in_fire  = valid_i & ready_reg;
   assign out_fire = valid_o & ready_i;

   // State, payload and registered-ready flops; reset beats flush and handshakes.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg  <= EMPTY;
         main_d_reg <= '0;
         skid_d_reg <= '0;
         ready_reg  <= 1'b1;
      end else begin
         state_reg  <= state_next;
         main_d_reg <= main_d_next;
         skid_d_reg <= skid_d_next;
         ready_reg  <= ready_next;
      end
   end

   // Next occupancy and payload moves; flush empties the stage, data flops hold.
   always_comb begin
      state_next  = state_reg;
      main_d_next = main_d_reg;
      skid_d_next = skid_d_reg;
      if (flush) begin
         state_next = EMPTY;
      end else begin
         case (state_reg)
            EMPTY: begin
               if (in_fire) begin
                  main_d_next = data_i;
                  state_next  = ONE;
               end
            end
            ONE: begin
               if (in_fire && out_fire) begin
                  main_d_next = data_i;
               end else if (in_fire) begin
                  skid_d_next = data_i;
                  state_next  = TWO;
               end else if (out_fire) begin
                  state_next  = EMPTY;
               end
            end
            TWO: begin
               // ready_o is low here, so only the drain side can move.
               if (out_fire) begin
                  main_d_next = skid_d_reg;
                  state_next  = ONE;
               end
            end
            default: begin
               state_next = EMPTY;
            end
         endcase
      end
      // Ready is precomputed from the next occupancy so it can be a plain flop.
      ready_next = (state_next != TWO);
   end

   // Outputs come directly from the main entry and the ready flop.
   always_comb begin
      valid_o = (state_reg != EMPTY);
      data_o  = main_d_reg;
      ready_o = ready_reg;
   end

`ifdef PIPE_STAGE_PERF_EN
   logic [CNT_WIDTH-1:0] stall_cnt_reg;

   // Saturating count of cycles where downstream refuses valid data; only rst clears it.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt_reg <= '0;
      end else if (valid_o && !ready_i && (stall_cnt_reg != '1)) begin
         stall_cnt_reg <= stall_cnt_reg + CNT_WIDTH'(1);
      end
   end

   assign stall_cnt_o = stall_cnt_reg;
`endif

endmodule : pipe_stage_skid

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench for pipe_stage_skid: a directed vector table followed by
// hand-written sequences (handshake scoreboard, and the stall counter when
// PIPE_STAGE_PERF_EN is defined).
module tb_pipe_stage_skid;

   localparam int W = 32;

   logic          clk;
   logic          rst;
   logic          flush;
   logic          valid_i;
   logic [W-1:0]  data_i;
   logic          ready_o;
   logic          valid_o;
   logic [W-1:0]  data_o;
   logic          ready_i;

   int n_vec;
   int n_err;

`ifdef PIPE_STAGE_PERF_EN
   logic [3:0] stall_cnt_o;

   pipe_stage_skid #(.WIDTH(W), .CNT_WIDTH(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .flush      (flush),
      .valid_i    (valid_i),
      .data_i     (data_i),
      .ready_o    (ready_o),
      .valid_o    (valid_o),
      .data_o     (data_o),
      .ready_i    (ready_i),
      .stall_cnt_o(stall_cnt_o)
   );
`else
   pipe_stage_skid #(.WIDTH(W)) dut (
      .clk    (clk),
      .rst    (rst),
      .flush  (flush),
      .valid_i(valid_i),
      .data_i (data_i),
      .ready_o(ready_o),
      .valid_o(valid_o),
      .data_o (data_o),
      .ready_i(ready_i)
   );
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic         rst;
      logic         flush;
      logic         valid;
      logic [W-1:0] data;
      logic         ready;
      logic         exp_valid;
      logic         exp_ready;
      logic         chk_data;
      logic [W-1:0] exp_data;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(logic r, logic f, logic v, logic [W-1:0] d, logic rdy,
                               logic ev, logic er, logic cd, logic [W-1:0] ed);
      vec_t t;
      t.rst = r; t.flush = f; t.valid = v; t.data = d; t.ready = rdy;
      t.exp_valid = ev; t.exp_ready = er; t.chk_data = cd; t.exp_data = ed;
      return t;
   endfunction

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic r, input logic f, input logic v, input logic [W-1:0] d,
                        input logic rdy);
      @(negedge clk);
      rst = r; flush = f; valid_i = v; data_i = d; ready_i = rdy;
   endtask

   logic [W-1:0] sb_q[$];
   logic [15:0]  rpat;
   logic [W-1:0] next_data;
   logic [W-1:0] held;
   logic [W-1:0] expd;
   logic         in_f, out_f, hold;
   int           drain;

   initial begin
      n_vec = 0;
      n_err = 0;
      rst = 1'b1; flush = 1'b0; valid_i = 1'b0; data_i = '0; ready_i = 1'b0;

      //            rst flush v  data          rdy  ev er cd exp_data
      // reset held two cycles with a valid input present
      vecs.push_back(mk(1, 0, 1, 32'hDEAD_BEEF, 0,  0, 1, 1, 32'h0));
      vecs.push_back(mk(1, 0, 1, 32'hDEAD_BEEF, 0,  0, 1, 1, 32'h0));
      // streaming 1,2,3; first item one cycle after rst drops
      vecs.push_back(mk(0, 0, 1, 32'h1,         1,  1, 1, 1, 32'h1));
      vecs.push_back(mk(0, 0, 1, 32'h2,         1,  1, 1, 1, 32'h2));
      vecs.push_back(mk(0, 0, 1, 32'h3,         1,  1, 1, 1, 32'h3));
      vecs.push_back(mk(0, 0, 0, 32'h0,         1,  0, 1, 0, 32'h0));
      // back-pressure: A then B, downstream stalls; C offered while full
      vecs.push_back(mk(0, 0, 1, 32'hA,         1,  1, 1, 1, 32'hA));
      vecs.push_back(mk(0, 0, 1, 32'hB,         0,  1, 0, 1, 32'hA));
      vecs.push_back(mk(0, 0, 1, 32'hC,         0,  1, 0, 1, 32'hA));
      vecs.push_back(mk(0, 0, 0, 32'h0,         0,  1, 0, 1, 32'hA));
      vecs.push_back(mk(0, 0, 0, 32'h0,         1,  1, 1, 1, 32'hB));
      vecs.push_back(mk(0, 0, 0, 32'h0,         1,  0, 1, 0, 32'h0));
      // flush in TWO with a new input offered
      vecs.push_back(mk(0, 0, 1, 32'h10,        0,  1, 1, 1, 32'h10));
      vecs.push_back(mk(0, 0, 1, 32'h11,        0,  1, 0, 1, 32'h10));
      vecs.push_back(mk(0, 1, 1, 32'h12,        0,  0, 1, 0, 32'h0));
      vecs.push_back(mk(0, 0, 0, 32'h0,         1,  0, 1, 0, 32'h0));
      // simultaneous in/out in ONE
      vecs.push_back(mk(0, 0, 1, 32'h20,        0,  1, 1, 1, 32'h20));
      vecs.push_back(mk(0, 0, 1, 32'h21,        1,  1, 1, 1, 32'h21));
      vecs.push_back(mk(0, 0, 0, 32'h0,         1,  0, 1, 0, 32'h0));
      // flush in ONE overriding a same-cycle in_fire
      vecs.push_back(mk(0, 0, 1, 32'h30,        0,  1, 1, 1, 32'h30));
      vecs.push_back(mk(0, 1, 1, 32'h31,        1,  0, 1, 0, 32'h0));
      vecs.push_back(mk(0, 0, 0, 32'h0,         1,  0, 1, 0, 32'h0));
      // reset mid-transfer from TWO beats the handshake
      vecs.push_back(mk(0, 0, 1, 32'h40,        0,  1, 1, 1, 32'h40));
      vecs.push_back(mk(0, 0, 1, 32'h41,        0,  1, 0, 1, 32'h40));
      vecs.push_back(mk(1, 0, 1, 32'h42,        1,  0, 1, 1, 32'h0));
      vecs.push_back(mk(0, 0, 0, 32'h0,         1,  0, 1, 1, 32'h0));

      // Directed table: drive on falling edge, check just after the rising edge.
      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].rst, vecs[i].flush, vecs[i].valid, vecs[i].data, vecs[i].ready);
         @(posedge clk);
         #1;
         check($sformatf("v%0d_valid_o", i), {31'b0, valid_o}, {31'b0, vecs[i].exp_valid});
         check($sformatf("v%0d_ready_o", i), {31'b0, ready_o}, {31'b0, vecs[i].exp_ready});
         if (vecs[i].chk_data)
            check($sformatf("v%0d_data_o", i), data_o, vecs[i].exp_data);
         $display("vec %0d: v_i=%0b d_i=%h r_i=%0b -> valid_o=%0b data_o=%h ready_o=%0b",
                  i, vecs[i].valid, vecs[i].data, vecs[i].ready, valid_o, data_o, ready_o);
      end

      // Handshake scoreboard: irregular valid/ready, order and hold stability checked.
      rpat      = 16'b1011_0010_1110_0100;
      next_data = 32'h100;
      for (int i = 0; i < 80; i++) begin
         @(negedge clk);
         rst = 1'b0; flush = 1'b0;
         valid_i = ((i % 5) != 3);
         ready_i = rpat[i % 16];
         data_i  = next_data;
         in_f  = valid_i & ready_o;
         out_f = valid_o & ready_i;
         hold  = valid_o & !ready_i;
         held  = data_o;
         if (out_f) begin
            n_vec++;
            if (sb_q.size() == 0) begin
               n_err++;
               $display("FAIL sb_spurious: got %h, expected no output", data_o);
            end else begin
               expd = sb_q.pop_front();
               n_vec--;
               check("sb_order", data_o, expd);
            end
         end
         if (in_f) begin
            sb_q.push_back(data_i);
            next_data = next_data + 1;
         end
         @(posedge clk);
         #1;
         if (hold) begin
            check("hold_valid", {31'b0, valid_o}, 32'h1);
            check("hold_data", data_o, held);
         end
         $display("sb %0d: in=%0b out=%0b valid_o=%0b data_o=%h ready_o=%0b",
                  i, in_f, out_f, valid_o, data_o, ready_o);
      end
      // Drain with a bounded cycle budget.
      drain = 0;
      while (sb_q.size() != 0 && drain < 10) begin
         @(negedge clk);
         valid_i = 1'b0; ready_i = 1'b1;
         if (valid_o) begin
            expd = sb_q.pop_front();
            check("drain_order", data_o, expd);
         end
         drain++;
      end
      @(negedge clk);
      valid_i = 1'b0; ready_i = 1'b1;
      @(posedge clk);
      #1;
      check("drain_left", sb_q.size(), 32'h0);
      check("drain_valid_o", {31'b0, valid_o}, 32'h0);

`ifdef PIPE_STAGE_PERF_EN
      // Stall counter: saturate, survive flush, clear on reset.
      drive(1, 0, 0, 32'h0, 0);
      @(posedge clk); #1;
      check("cnt_reset", {28'b0, stall_cnt_o}, 32'h0);
      drive(0, 0, 1, 32'h50, 0);
      @(posedge clk); #1;
      check("cnt_first", {28'b0, stall_cnt_o}, 32'h0);
      drive(0, 0, 0, 32'h0, 0);
      @(posedge clk); #1;
      check("cnt_one", {28'b0, stall_cnt_o}, 32'h1);
      for (int i = 0; i < 20; i++) begin
         drive(0, 0, 0, 32'h0, 0);
         @(posedge clk);
      end
      #1;
      check("cnt_sat", {28'b0, stall_cnt_o}, 32'hF);
      drive(0, 1, 0, 32'h0, 0);
      @(posedge clk); #1;
      check("cnt_flush_valid_o", {31'b0, valid_o}, 32'h0);
      check("cnt_after_flush", {28'b0, stall_cnt_o}, 32'hF);
      drive(1, 0, 0, 32'h0, 0);
      @(posedge clk); #1;
      check("cnt_after_rst", {28'b0, stall_cnt_o}, 32'h0);
      $display("perf: stall_cnt_o=%0d after reset", stall_cnt_o);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   // Global time limit so the run always ends.
   initial begin
      #200000;
      $display("FAIL timeout: got no finish, expected finish before 200000");
      $fatal(1, "timeout");
   end

endmodule : tb_pipe_stage_skid
